// File: rtl/sram_port_arbiter_if.sv
// One SRAM-like request/response port (req/addr_ok/data_ok handshake).
interface sram_port_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Generic FIFO: 0-cycle read of head, registered push/pop; caller must not push when full or pop when empty.
module fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
endmodule

// Arbitrates inst/data onto one SRAM port (data first, grant held until addr_ok); zero added latency.
// Backpressure: mem_req drops when DEPTH transactions are outstanding; responses routed by in-order tag FIFO.
module sram_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    sram_port_arbiter_if.slave          inst,
    sram_port_arbiter_if.slave          data,
    sram_port_arbiter_if.master         mem,
    output logic                        idle
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_fields_t;

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_t;

    lock_state_t lock_state, lock_state_nxt;
    logic        lock;
    logic        lock_owner, lock_owner_nxt;
    logic        owner;       // 0 = inst, 1 = data
    logic        owner_req;
    logic        accept;
    logic        pop;
    logic        head;
    logic        full;
    logic        empty;
    logic [PW:0] count;

    req_fields_t inst_fields, data_fields, mem_fields;

    assign inst_fields = {inst.wr, inst.size, inst.addr, inst.wstrb, inst.wdata};
    assign data_fields = {data.wr, data.size, data.addr, data.wstrb, data.wdata};

    assign lock = (lock_state == LOCK_HELD);

    always_comb begin
        owner      = data.req;
        owner_req  = data.req | inst.req;
        if (lock) begin
            owner     = lock_owner;
            owner_req = lock_owner ? data.req : inst.req;
        end
        mem_fields = '0;
        if (owner_req) mem_fields = owner ? data_fields : inst_fields;
    end

    // Full gating uses registered count only, so no data_ok -> req path exists.
    assign mem.req   = owner_req & ~full & ~reset;
    assign mem.wr    = mem_fields.wr;
    assign mem.size  = mem_fields.size;
    assign mem.addr  = mem_fields.addr;
    assign mem.wstrb = mem_fields.wstrb;
    assign mem.wdata = mem_fields.wdata;

    assign accept       = mem.req & mem.addr_ok;
    assign inst.addr_ok = accept & ~owner;
    assign data.addr_ok = accept & owner;

    assign pop          = mem.data_ok & ~empty & ~reset;
    assign inst.data_ok = pop & ~head;
    assign data.data_ok = pop & head;
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    assign idle = (reset | empty) & ~inst.req & ~data.req;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state <= LOCK_OPEN;
            lock_owner <= 1'b0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_owner <= lock_owner_nxt;
        end
    end

    always_comb begin
        lock_state_nxt = lock_state;
        lock_owner_nxt = lock_owner;
        case (lock_state)
            LOCK_OPEN: begin
                if (mem.req && !mem.addr_ok) begin
                    lock_state_nxt = LOCK_HELD;
                    lock_owner_nxt = owner;
                end
            end
            LOCK_HELD: begin
                // Also release if the owner withdraws its request mid-wait.
                if (accept || !owner_req) lock_state_nxt = LOCK_OPEN;
            end
            default: lock_state_nxt = LOCK_OPEN;
        endcase
    end

    fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (owner),
        .pop      (pop),
        .head_dat (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter against a queue-based reference model.
module tb_sram_port_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic idle;

    sram_port_arbiter_if inst_if ();
    sram_port_arbiter_if data_if ();
    sram_port_arbiter_if mem_if ();

    sram_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_if),
        .data  (data_if),
        .mem   (mem_if),
        .idle  (idle)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of owners of outstanding transactions, plus grant lock.
    bit tq[$];
    bit m_lock;
    bit m_lock_owner;
    bit e_own, e_own_req, e_mreq, e_iaok, e_daok, e_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        bit          full;
        logic [31:0] e_addr, e_wdata;
        logic        e_wr;
        @(negedge clk);
        full = (tq.size() == DEPTH);
        if (m_lock) begin
            e_own     = m_lock_owner;
            e_own_req = m_lock_owner ? data_if.req : inst_if.req;
        end else begin
            e_own     = data_if.req;
            e_own_req = data_if.req | inst_if.req;
        end
        e_mreq  = e_own_req && !full && !reset;
        e_addr  = !e_own_req ? 32'h0 : (e_own ? data_if.addr  : inst_if.addr);
        e_wdata = !e_own_req ? 32'h0 : (e_own ? data_if.wdata : inst_if.wdata);
        e_wr    = !e_own_req ? 1'b0  : (e_own ? data_if.wr    : inst_if.wr);
        e_iaok  = e_mreq && mem_if.addr_ok && !e_own;
        e_daok  = e_mreq && mem_if.addr_ok && e_own;
        e_pop   = mem_if.data_ok && (tq.size() > 0) && !reset;

        check({tag, "/mem_req"},      32'(mem_if.req),       32'(e_mreq));
        check({tag, "/mem_addr"},     mem_if.addr,           e_addr);
        check({tag, "/mem_wdata"},    mem_if.wdata,          e_wdata);
        check({tag, "/mem_wr"},       32'(mem_if.wr),        32'(e_wr));
        check({tag, "/inst_addr_ok"}, 32'(inst_if.addr_ok),  32'(e_iaok));
        check({tag, "/data_addr_ok"}, 32'(data_if.addr_ok),  32'(e_daok));
        check({tag, "/inst_data_ok"}, 32'(inst_if.data_ok),  32'(e_pop && (tq[0] == 1'b0)));
        check({tag, "/data_data_ok"}, 32'(data_if.data_ok),  32'(e_pop && (tq[0] == 1'b1)));
        check({tag, "/rdata"},        data_if.rdata,         mem_if.rdata);
        check({tag, "/idle"},         32'(idle),
              32'((reset || tq.size() == 0) && !inst_if.req && !data_if.req));
        check({tag, "/count"},        32'(dut.count),        32'(tq.size()));

        @(posedge clk);
        if (reset) begin
            tq.delete();
            m_lock       = 1'b0;
            m_lock_owner = 1'b0;
        end else begin
            if (e_pop) void'(tq.pop_front());
            if (e_mreq && mem_if.addr_ok) tq.push_back(e_own);
            if (!m_lock) begin
                if (e_mreq && !mem_if.addr_ok) begin
                    m_lock       = 1'b1;
                    m_lock_owner = e_own;
                end
            end else if ((e_mreq && mem_if.addr_ok) || !e_own_req) begin
                m_lock = 1'b0;
            end
        end
        #1;
    endtask

    task automatic new_req(input bit is_data);
        if (is_data) begin
            data_if.req   = 1'b1;
            data_if.wr    = 1'($urandom_range(0, 1));
            data_if.size  = 2'($urandom_range(0, 2));
            data_if.addr  = $urandom;
            data_if.wstrb = 4'($urandom);
            data_if.wdata = $urandom;
        end else begin
            inst_if.req   = 1'b1;
            inst_if.wr    = 1'b0;
            inst_if.size  = 2'd2;
            inst_if.addr  = $urandom;
            inst_if.wstrb = 4'h0;
            inst_if.wdata = $urandom;
        end
    endtask

    initial begin
        reset          = 1'b1;
        inst_if.req    = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
        inst_if.addr   = 32'h0; inst_if.wstrb = 4'h0; inst_if.wdata = 32'h0;
        data_if.req    = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
        data_if.addr   = 32'h0; data_if.wstrb = 4'hf; data_if.wdata = 32'h0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
        step("reset");
        step("reset2");
        reset = 1'b0;

        // Priority: data wins, then inst, responses return in order.
        inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0000;
        data_if.req = 1'b1; data_if.addr = 32'h0000_1000; data_if.wdata = 32'h1234_5678;
        mem_if.addr_ok = 1'b1;
        step("prio_c0");
        data_if.req = 1'b0;
        step("prio_c1");
        inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h0000_AAAA;
        step("prio_rsp0");
        mem_if.rdata = 32'h0000_BBBB;
        step("prio_rsp1");
        mem_if.data_ok = 1'b0;

        // Lock: inst waits for addr_ok while data arrives.
        inst_if.req = 1'b1; inst_if.addr = 32'h1c00_0040;
        step("lock_c0");
        data_if.req = 1'b1; data_if.addr = 32'h0000_2000;
        step("lock_c1");
        step("lock_c2");
        step("lock_c3");
        mem_if.addr_ok = 1'b1;
        step("lock_aok");
        inst_if.req = 1'b0;
        step("lock_data");
        data_if.req = 1'b0; mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1;
        step("lock_rsp0");
        step("lock_rsp1");
        mem_if.data_ok = 1'b0;

        // Full: four outstanding data requests block the fifth.
        data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_if.addr = 32'h0000_3000 + 32'(i * 4);
            step("full_fill");
        end
        mem_if.data_ok = 1'b1;
        step("full_pop");
        mem_if.data_ok = 1'b0;
        step("full_resume");
        data_if.req = 1'b0; mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1;
        for (int i = 0; i < 4; i++) step("full_drain");
        mem_if.data_ok = 1'b0;

        // Simultaneous push/pop at count 2, enough iterations to wrap pointers.
        mem_if.addr_ok = 1'b1; inst_if.req = 1'b1;
        step("pp_fill0");
        inst_if.req = 1'b0; data_if.req = 1'b1;
        step("pp_fill1");
        mem_if.data_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_if.req  = 1'(i % 2);
            inst_if.req  = 1'((i + 1) % 2);
            mem_if.rdata = $urandom;
            step("pp_loop");
        end
        inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        step("pp_drain0");
        step("pp_drain1");

        // Spurious response on empty FIFO.
        step("spurious");
        mem_if.data_ok = 1'b0;

        // Reset mid-operation with three outstanding and one locked request.
        data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) step("rst_fill");
        data_if.req = 1'b0; inst_if.req = 1'b1; mem_if.addr_ok = 1'b0;
        step("rst_lock");
        reset = 1'b1;
        step("rst_assert");
        reset = 1'b0; inst_if.req = 1'b0; mem_if.data_ok = 1'b1;
        step("rst_drop");
        mem_if.data_ok = 1'b0;
        step("rst_after");

        // Randomized traffic; requesters hold req and fields until addr_ok.
        for (int i = 0; i < 500; i++) begin
            if (!inst_if.req && $urandom_range(0, 2) == 0) new_req(1'b0);
            if (!data_if.req && $urandom_range(0, 2) == 0) new_req(1'b1);
            mem_if.addr_ok = 1'($urandom_range(0, 1));
            mem_if.data_ok = ($urandom_range(0, 2) == 0);
            mem_if.rdata   = $urandom;
            reset          = ($urandom_range(0, 99) == 0);
            step("rand");
            if (e_iaok) inst_if.req = 1'b0;
            if (e_daok) data_if.req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one downstream SRAM-like port (req/addr_ok/data_ok) between the core's instruction-fetch and data-access requesters. The block sits between the CPU top and the single memory-side bridge. It arbitrates request phases with data-over-inst priority and holds the grant stable while a request waits for `addr_ok`. It records each accepted transaction's owner in an in-order tag FIFO and uses that FIFO to route `data_ok`/`rdata` back to the correct requester.

## Interface
- `DEPTH`, default 4: maximum outstanding transactions (accepted, not yet answered). Must be a power of 2, ≥2.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `inst_req`, `inst_wr`  in  1  inst request / write flag
- `inst_size`  in  2  access size
- `inst_addr`, `inst_wdata`  in  32  address / write data
- `inst_wstrb`  in  4  byte strobes
- `inst_addr_ok`, `inst_data_ok`  out  1  request accepted / response valid
- `inst_rdata`  out  32  read data
- `data_req` … `data_rdata`: same set as `inst_*`, for the data requester
- `mem_req`, `mem_wr`  out  1  downstream request / write flag
- `mem_size`  out  2  downstream access size
- `mem_addr`, `mem_wdata`  out  32  downstream address / write data
- `mem_wstrb`  out  4  downstream byte strobes
- `mem_addr_ok`, `mem_data_ok`  in  1  downstream accept / response
- `mem_rdata`  in  32  downstream read data
- `idle`  out  1  no outstanding transaction and no pending request

## Operation
- Owner selection, unlocked: `data` if `data_req`, else `inst` if `inst_req`, else none.
- Lock: if `mem_req & ~mem_addr_ok` at a clock edge, set `lock=1` and latch the owner into `lock_owner`. While locked, owner = `lock_owner` regardless of the other requester.
- Lock clears on the edge where `mem_addr_ok` is seen. It also clears if the locked owner drops its req; requesters must not do this (protocol rule), but the arbiter recovers.
- `mem_req` = owner's req & ~full & ~reset. `mem_wr/size/addr/wstrb/wdata` = owner's fields, driven combinationally. When no owner, drive zeros.
- `<owner>_addr_ok` = `mem_addr_ok & mem_req`. The non-owner's `addr_ok` = 0.
- Push: `mem_req & mem_addr_ok` pushes the owner tag (0=inst, 1=data) at the edge.
- Pop: `mem_data_ok` with the FIFO non-empty pops the head.
  - `inst_data_ok = mem_data_ok & nonempty & head==0`
  - `data_data_ok = mem_data_ok & nonempty & head==1`
  - `inst_rdata = data_rdata = mem_rdata` (broadcast).
- Writes also receive `data_ok` and are routed identically.
- Counter: `count` is 0…DEPTH, width log2(DEPTH)+1. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `full = (count==DEPTH)`.
- Boundaries:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: `mem_req` = 0 even if a pop occurs this cycle. No combinational data_ok→req path.
  - `mem_data_ok` with empty FIFO: dropped. Neither `data_ok` asserts and no state changes.
  - Lock held while full: `lock` stays set, `mem_req` is 0 until a slot frees, then the same owner is re-presented.
- `idle = (count==0) & ~inst_req & ~data_req`.

## Timing
- Zero added latency: request, `addr_ok` and `data_ok` paths are combinational. The tag FIFO, `count`, `lock` and `lock_owner` update on posedge `clk`.
- A response may arrive in the cycle after its `addr_ok`. The tag written at that edge is the head in the next cycle if the FIFO was empty.
- Reset (synchronous, any time including mid-transaction): `count`, pointers, `lock`, `lock_owner` ← 0.
  - While reset is high: `mem_req`, both `addr_ok`, both `data_ok` = 0.
  - `idle` = 1 while reset is high if no reqs are asserted.
  - Outstanding responses from before reset are dropped; the empty-FIFO rule applies.
- At most one push and one pop per cycle.

## Test plan
- **Priority:** `inst_req=data_req=1`, `mem_addr_ok=1`, data addr 0x1000, inst addr 0x1c000000 → cycle 0 `mem_addr=0x1000`, `data_addr_ok=1`, `inst_addr_ok=0`. Cycle 1 inst issued. Two `mem_data_ok` responses with rdata 0xAAAA, 0xBBBB → `data_data_ok` then `inst_data_ok`, in that order.
- **Lock:** inst requests alone with `mem_addr_ok=0` for 3 cycles; `data_req` rises in cycle 1 → `mem_addr` stays the inst address through cycle 3. When `addr_ok` arrives, `inst_addr_ok=1`. Data is granted in the next cycle.
- **Full:** DEPTH=4; issue 4 data requests with no responses → 5th request gives `mem_req=0`, `data_addr_ok=0`. One `mem_data_ok` → `mem_req` returns to 1 the following cycle.
- **Simultaneous push/pop:** count=2; in one cycle `mem_addr_ok=1` and `mem_data_ok=1` → count stays 2 and the head tag routes correctly. Repeat 10 times so the pointers wrap.
- **Spurious response:** `mem_data_ok=1` with count=0 → both `data_ok`=0 and count stays 0.
- **Reset mid-operation:** 3 outstanding, one locked request; assert reset for 1 cycle → count=0, lock=0, `mem_req=0` during reset. A subsequent `mem_data_ok` is dropped.
